// File: rtl/demux_1to2_stream_pkg.sv
// Shared types and constants for the 1:2 stream demultiplexer.
// Optional packet statistics are enabled with DEMUX_1TO2_STATS_EN.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE0 = 2'd1,
        ROUTE1 = 2'd2
    } route_state_t;

    localparam int STATS_W = 16;

endpackage

// File: rtl/demux_1to2_stream_if.sv
// Stream bundle for demux_1to2_stream: one input stream and two output streams.
// The slave modport is the demux view; the master modport is the producer/consumer view.
interface demux_1to2_stream_if #(
    parameter int n = 8
);
    logic         en;
    logic         sel;
    logic [n-1:0] d;
    logic         d_valid;
    logic         d_last;
    logic         d_ready;
    logic [n-1:0] q0;
    logic         q0_valid;
    logic         q0_last;
    logic         q0_ready;
    logic [n-1:0] q1;
    logic         q1_valid;
    logic         q1_last;
    logic         q1_ready;

    modport slave (
        input  en, sel, d, d_valid, d_last, q0_ready, q1_ready,
        output d_ready, q0, q0_valid, q0_last, q1, q1_valid, q1_last
    );

    modport master (
        output en, sel, d, d_valid, d_last, q0_ready, q1_ready,
        input  d_ready, q0, q0_valid, q0_last, q1, q1_valid, q1_last
    );
endinterface

// File: rtl/demux_1to2_stream_out_slot.sv
// One-entry output register slice holding data/last/valid for one demux output.
// A load in the same cycle as a drain replaces the beat and keeps valid high.
module out_slot #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [n-1:0] i_data,
    input  logic         i_last,
    input  logic         i_ready,
    output logic [n-1:0] o_data,
    output logic         o_last,
    output logic         o_valid,
    output logic         o_can_accept
);
    logic [n-1:0] r_data;
    logic         r_last;
    logic         r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_last  <= i_last;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data       = r_data;
    assign o_last       = r_last;
    assign o_valid      = r_valid;
    assign o_can_accept = !r_valid || i_ready;
endmodule

// File: rtl/demux_1to2_stream.sv
// Registered 1:2 packet demultiplexer; route is latched from sel on each packet's first beat.
// Define DEMUX_1TO2_STATS_EN to add per-output completed-packet counters.
module demux_1to2_stream
    import demux_pkg::*;
#(
    parameter int n = 8
) (
    input  logic                clk,
    input  logic                rst,
    demux_1to2_stream_if.slave  bus
`ifdef DEMUX_1TO2_STATS_EN
    ,
    output logic [STATS_W-1:0]  pkt_cnt0,
    output logic [STATS_W-1:0]  pkt_cnt1
`endif
);
    route_state_t r_state;
    route_state_t w_state_next;
    logic         w_target;
    logic         w_can0;
    logic         w_can1;
    logic         w_accept;
    logic         w_load0;
    logic         w_load1;

    // Mid-packet the route is locked; sel only matters while idle.
    always_comb begin
        w_target = 1'b0;
        case (r_state)
            IDLE:    w_target = bus.sel;
            ROUTE1:  w_target = 1'b1;
            default: w_target = 1'b0;
        endcase
    end

    assign bus.d_ready = bus.en && !rst && (w_target ? w_can1 : w_can0);
    assign w_accept    = bus.d_valid && bus.d_ready;
    assign w_load0     = w_accept && !w_target;
    assign w_load1     = w_accept && w_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (!bus.d_last) begin
                        w_state_next = bus.sel ? ROUTE1 : ROUTE0;
                    end
                end
                ROUTE0, ROUTE1: begin
                    if (bus.d_last) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    out_slot #(.n(n)) u_slot0 (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load0),
        .i_data       (bus.d),
        .i_last       (bus.d_last),
        .i_ready      (bus.q0_ready),
        .o_data       (bus.q0),
        .o_last       (bus.q0_last),
        .o_valid      (bus.q0_valid),
        .o_can_accept (w_can0)
    );

    out_slot #(.n(n)) u_slot1 (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load1),
        .i_data       (bus.d),
        .i_last       (bus.d_last),
        .i_ready      (bus.q1_ready),
        .o_data       (bus.q1),
        .o_last       (bus.q1_last),
        .o_valid      (bus.q1_valid),
        .o_can_accept (w_can1)
    );

`ifdef DEMUX_1TO2_STATS_EN
    logic [STATS_W-1:0] r_cnt0;
    logic [STATS_W-1:0] r_cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (bus.q0_valid && bus.q0_ready && bus.q0_last) r_cnt0 <= r_cnt0 + 1'b1;
            if (bus.q1_valid && bus.q1_ready && bus.q1_last) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign pkt_cnt0 = r_cnt0;
    assign pkt_cnt1 = r_cnt1;
`endif
endmodule

// File: tb/tb_demux_1to2_stream.sv
// Self-checking bench for demux_1to2_stream: directed scenarios plus a randomized run
// checked against a packet-level reference model (per-output beat queues).
module tb_demux_1to2_stream;
    logic clk;
    logic rst;
    int unsigned errors;
    int unsigned checks;

    demux_1to2_stream_if #(.n(8)) bus ();

`ifdef DEMUX_1TO2_STATS_EN
    logic [15:0] pkt_cnt0;
    logic [15:0] pkt_cnt1;
    demux_1to2_stream #(.n(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1)
    );
`else
    demux_1to2_stream #(.n(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] data, input logic l);
        bus.d_valid = v;
        bus.sel     = s;
        bus.d       = data;
        bus.d_last  = l;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b1; bus.q0_ready = 1'b1; bus.q1_ready = 1'b1;
        drive(1'b1, 1'b0, 8'hA5, 1'b1);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.d_ready, bus.q0_valid, bus.q1_valid, bus.q0, bus.q1} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v0=%b v1=%b q0=%h q1=%h, want all 0",
                     bus.d_ready, bus.q0_valid, bus.q1_valid, bus.q0, bus.q1);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.d_ready !== 1'b1 || bus.q0_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b v0=%b, want rdy=1 v0=0", bus.d_ready, bus.q0_valid);
        end
        step();
        bus.d_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.q0_valid, bus.q0_last, bus.q0, bus.q1_valid} !== {1'b1, 1'b1, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL reset_first_beat: got v0=%b l0=%b q0=%h v1=%b, want 1 1 a5 0",
                     bus.q0_valid, bus.q0_last, bus.q0, bus.q1_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.q0_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain: got v0=%b, want 0", bus.q0_valid);
        end
    endtask

    task automatic test_single_beat();
        step();
        drive(1'b1, 1'b1, 8'h3C, 1'b1);
        step();
        bus.d_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.q1_valid, bus.q1_last, bus.q1, bus.q0_valid} !== {1'b1, 1'b1, 8'h3C, 1'b0}) begin
            errors++;
            $display("FAIL single_beat: got v1=%b l1=%b q1=%h v0=%b, want 1 1 3c 0",
                     bus.q1_valid, bus.q1_last, bus.q1, bus.q0_valid);
        end
    endtask

    task automatic test_packet_lock();
        logic [7:0] beats [3];
        logic       sels  [3];
        logic       lasts [3];
        beats = '{8'h01, 8'h02, 8'h03};
        sels  = '{1'b0, 1'b1, 1'b1};
        lasts = '{1'b0, 1'b0, 1'b1};
        step();
        drive(1'b1, sels[0], beats[0], lasts[0]);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i < 2) drive(1'b1, sels[i+1], beats[i+1], lasts[i+1]);
            else       bus.d_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({bus.q0_valid, bus.q0_last, bus.q0, bus.q1_valid} !== {1'b1, lasts[i], beats[i], 1'b0}) begin
                errors++;
                $display("FAIL packet_lock[%0d]: got v0=%b l0=%b q0=%h v1=%b, want 1 %b %h 0",
                         i, bus.q0_valid, bus.q0_last, bus.q0, bus.q1_valid, lasts[i], beats[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        step();
        bus.q0_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h11, 1'b1);
        step();
        // q0 stalled; a q1 packet must still flow
        drive(1'b1, 1'b1, 8'h44, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.d_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_q1_ready: got rdy=%b, want 1", bus.d_ready);
        end
        step();
        drive(1'b1, 1'b0, 8'h45, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.q1_valid, bus.q1, bus.d_ready} !== {1'b1, 8'h44, 1'b1}) begin
            errors++;
            $display("FAIL bp_q1_flow0: got v1=%b q1=%h rdy=%b, want 1 44 1", bus.q1_valid, bus.q1, bus.d_ready);
        end
        step();
        drive(1'b1, 1'b0, 8'h22, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.q1_valid, bus.q1_last, bus.q1, bus.d_ready, bus.q0_valid, bus.q0} !==
            {1'b1, 1'b1, 8'h45, 1'b0, 1'b1, 8'h11}) begin
            errors++;
            $display("FAIL bp_stall: got v1=%b l1=%b q1=%h rdy=%b v0=%b q0=%h, want 1 1 45 0 1 11",
                     bus.q1_valid, bus.q1_last, bus.q1, bus.d_ready, bus.q0_valid, bus.q0);
        end
        step();
        @(negedge clk);
        checks++;
        if ({bus.q0_valid, bus.q0} !== {1'b1, 8'h11}) begin
            errors++;
            $display("FAIL bp_hold: got v0=%b q0=%h, want 1 11", bus.q0_valid, bus.q0);
        end
        step();
        bus.q0_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.d_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got rdy=%b, want 1", bus.d_ready);
        end
        step();
        bus.d_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.q0_valid, bus.q0} !== {1'b1, 8'h22}) begin
            errors++;
            $display("FAIL bp_release_load: got v0=%b q0=%h, want 1 22", bus.q0_valid, bus.q0);
        end
    endtask

    task automatic test_en_pause();
        step();
        drive(1'b1, 1'b1, 8'h51, 1'b0);
        step();
        bus.en = 1'b0;
        drive(1'b1, 1'b0, 8'h52, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.d_ready !== 1'b0 || bus.q1_valid !== (i == 0)) begin
                errors++;
                $display("FAIL en_pause[%0d]: got rdy=%b v1=%b, want rdy=0 v1=%b", i, bus.d_ready, bus.q1_valid, i == 0);
            end
            step();
        end
        bus.en = 1'b1;
        step();
        drive(1'b1, 1'b0, 8'h53, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.q1_valid, bus.q1, bus.q0_valid} !== {1'b1, 8'h52, 1'b0}) begin
            errors++;
            $display("FAIL en_resume: got v1=%b q1=%h v0=%b, want 1 52 0", bus.q1_valid, bus.q1, bus.q0_valid);
        end
        step();
        bus.d_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.q1_valid, bus.q1_last, bus.q1, bus.q0_valid} !== {1'b1, 1'b1, 8'h53, 1'b0}) begin
            errors++;
            $display("FAIL en_last: got v1=%b l1=%b q1=%h v0=%b, want 1 1 53 0",
                     bus.q1_valid, bus.q1_last, bus.q1, bus.q0_valid);
        end
    endtask

    task automatic test_mid_reset();
        step();
        bus.q0_ready = 1'b0; bus.q1_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h61, 1'b1);
        step();
        drive(1'b1, 1'b1, 8'h62, 1'b0);
        step();
        bus.d_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.q0_valid, bus.q1_valid} !== 2'b11) begin
            errors++;
            $display("FAIL mid_reset_fill: got v0=%b v1=%b, want 1 1", bus.q0_valid, bus.q1_valid);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.q0_ready = 1'b1; bus.q1_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.q0_valid, bus.q1_valid, bus.q0, bus.q1} !== 18'd0) begin
            errors++;
            $display("FAIL mid_reset_clear: got v0=%b v1=%b q0=%h q1=%h, want all 0",
                     bus.q0_valid, bus.q1_valid, bus.q0, bus.q1);
        end
        step();
        drive(1'b1, 1'b0, 8'h63, 1'b1);
        step();
        bus.d_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.q0_valid, bus.q0, bus.q1_valid} !== {1'b1, 8'h63, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_idle: got v0=%b q0=%h v1=%b, want 1 63 0", bus.q0_valid, bus.q0, bus.q1_valid);
        end
    endtask

    task automatic test_random(input int unsigned cycles);
        logic [8:0] exp0 [$];
        logic [8:0] exp1 [$];
        bit   in_pkt;
        bit   route;
        bit   hold;
        bit   tgt;
        bit   exp_rdy;
        in_pkt = 1'b0; route = 1'b0; hold = 1'b0;
        step();
        rst = 1'b1;
        bus.d_valid = 1'b0;
        step();
        rst = 1'b0;
        for (int unsigned c = 0; c < cycles; c++) begin
            if (!hold) begin
                bus.d_valid = ($urandom_range(0, 3) != 0);
                bus.d       = 8'($urandom);
                bus.d_last  = ($urandom_range(0, 3) == 0);
            end
            bus.sel      = 1'($urandom);
            bus.en       = ($urandom_range(0, 7) != 0);
            bus.q0_ready = ($urandom_range(0, 3) != 0);
            bus.q1_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            tgt = in_pkt ? route : bus.sel;
            exp_rdy = bus.en && (tgt ? (exp1.size() == 0 || bus.q1_ready)
                                     : (exp0.size() == 0 || bus.q0_ready));
            checks++;
            if (bus.d_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_ready c=%0d: got %b, want %b", c, bus.d_ready, exp_rdy);
            end
            checks++;
            if (bus.q0_valid !== (exp0.size() != 0) || (exp0.size() != 0 && {bus.q0_last, bus.q0} !== exp0[0])) begin
                errors++;
                $display("FAIL rand_q0 c=%0d: got v=%b {l,q}=%h, want v=%b {l,q}=%h",
                         c, bus.q0_valid, {bus.q0_last, bus.q0}, exp0.size() != 0,
                         (exp0.size() != 0) ? exp0[0] : 9'h0);
            end
            checks++;
            if (bus.q1_valid !== (exp1.size() != 0) || (exp1.size() != 0 && {bus.q1_last, bus.q1} !== exp1[0])) begin
                errors++;
                $display("FAIL rand_q1 c=%0d: got v=%b {l,q}=%h, want v=%b {l,q}=%h",
                         c, bus.q1_valid, {bus.q1_last, bus.q1}, exp1.size() != 0,
                         (exp1.size() != 0) ? exp1[0] : 9'h0);
            end
            if (exp0.size() != 0 && bus.q0_ready) void'(exp0.pop_front());
            if (exp1.size() != 0 && bus.q1_ready) void'(exp1.pop_front());
            if (bus.d_valid && exp_rdy) begin
                if (tgt) exp1.push_back({bus.d_last, bus.d});
                else     exp0.push_back({bus.d_last, bus.d});
                if (!in_pkt && !bus.d_last) begin
                    in_pkt = 1'b1;
                    route  = bus.sel;
                end else if (in_pkt && bus.d_last) begin
                    in_pkt = 1'b0;
                end
            end
            hold = bus.d_valid && !exp_rdy;
            step();
        end
        bus.d_valid = 1'b0;
        bus.en = 1'b1; bus.q0_ready = 1'b1; bus.q1_ready = 1'b1;
    endtask

`ifdef DEMUX_1TO2_STATS_EN
    task automatic test_stats();
        step();
        rst = 1'b1;
        bus.d_valid = 1'b0;
        bus.en = 1'b1; bus.q0_ready = 1'b1; bus.q1_ready = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b1);
            step();
        end
        drive(1'b1, 1'b1, 8'h70, 1'b0);
        step();
        drive(1'b1, 1'b1, 8'h71, 1'b1);
        step();
        bus.d_valid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (pkt_cnt0 !== 16'd3 || pkt_cnt1 !== 16'd1) begin
            errors++;
            $display("FAIL stats_count: got cnt0=%0d cnt1=%0d, want 3 1", pkt_cnt0, pkt_cnt1);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b1, 1'b0, 8'h5A, 1'b1);
        repeat (65535) @(posedge clk);
        #1;
        bus.d_valid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (pkt_cnt0 !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_preload: got cnt0=%h, want ffff", pkt_cnt0);
        end
        step();
        drive(1'b1, 1'b0, 8'h5B, 1'b1);
        step();
        bus.d_valid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (pkt_cnt0 !== 16'h0000) begin
            errors++;
            $display("FAIL stats_wrap: got cnt0=%h, want 0000", pkt_cnt0);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_beat();
        test_packet_lock();
        test_backpressure();
        test_en_pause();
        test_mid_reset();
        test_random(3000);
`ifdef DEMUX_1TO2_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
